// File: rtl/ul4_ctrl.sv
// Micro-sequencer driving an external 4-bit logic unit (ul4) through a stored
// program of operations on an accumulator: acc <= ul4(acc, b[i], s[i]).
module ul4_ctrl #(
  parameter int NSTEPS = 4,
  parameter int WIDTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prog_we,
  input  logic [2:0]       prog_addr,
  input  logic [WIDTH-1:0] prog_b,
  input  logic [1:0]       prog_s,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [2:0]       prog_len,
  output logic [WIDTH-1:0] ul_a,
  output logic [WIDTH-1:0] ul_b,
  output logic [1:0]       ul_s,
  input  logic [WIDTH-1:0] ul_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int AW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam int SW = $clog2(NSTEPS) + 1;
  localparam int MD = 1 << AW;
  localparam logic [3:0] N4 = 4'(NSTEPS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [SW-1:0]    r_step;
  logic [SW-1:0]    r_len_m1;
  logic             r_err;
  logic [WIDTH+1:0] r_mem [MD];

  logic             w_busy;
  logic             w_len_ok;
  logic             w_addr_ok;
  logic             w_last;
  logic [WIDTH+1:0] w_entry;

  assign w_busy    = (r_state == S_RUN);
  assign w_len_ok  = (prog_len != 3'd0) && ({1'b0, prog_len} <= N4);
  // Memory is sized to a power of two; the range guard keeps out-of-range
  // addresses from aliasing onto real entries.
  assign w_addr_ok = ({1'b0, prog_addr} < N4);
  assign w_last    = (r_step == r_len_m1);
  assign w_entry   = r_mem[r_step[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_result <= '0;
      r_step   <= '0;
      r_len_m1 <= '0;
      r_err    <= 1'b0;
      for (int unsigned i = 0; i < MD; i++) r_mem[i] <= '0;
    end else begin
      r_err <= 1'b0;
      if (prog_we && !w_busy && w_addr_ok)
        r_mem[prog_addr[AW-1:0]] <= {prog_b, prog_s};
      case (r_state)
        S_RUN: begin
          r_acc  <= ul_out;
          r_step <= r_step + SW'(1);
          if (w_last) begin
            r_result <= ul_out;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          if (start) begin
            if (w_len_ok) begin
              r_acc    <= a_in;
              r_step   <= '0;
              r_len_m1 <= SW'(prog_len - 3'd1);
              r_state  <= S_RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign busy   = w_busy;
  assign done   = (r_state == S_DONE);
  assign err    = r_err;
  assign result = r_result;
  assign ul_a   = w_busy ? r_acc : '0;
  assign ul_b   = w_busy ? w_entry[WIDTH+1:2] : '0;
  assign ul_s   = w_busy ? w_entry[1:0] : '0;

endmodule

// File: tb/tb_ul4_ctrl.sv
// Self-checking bench for ul4_ctrl with a behavioural ul4 and program model.
module tb_ul4_ctrl;

  logic       clk, reset, prog_we, start, busy, done, err;
  logic [2:0] prog_addr, prog_len;
  logic [3:0] prog_b, a_in, ul_a, ul_b, ul_out, result;
  logic [1:0] prog_s, ul_s;

  int checks = 0;
  int failures = 0;

  logic [3:0] m_b [8];
  logic [1:0] m_s [8];
  logic [3:0] m_result;

  ul4_ctrl #(.NSTEPS(4), .WIDTH(4)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_b(prog_b), .prog_s(prog_s), .start(start), .a_in(a_in),
    .prog_len(prog_len), .ul_a(ul_a), .ul_b(ul_b), .ul_s(ul_s),
    .ul_out(ul_out), .busy(busy), .done(done), .err(err), .result(result)
  );

  function automatic logic [3:0] ul4_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] s);
    case (s)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // External logic unit the controller drives
  assign ul_out = ul4_f(ul_a, ul_b, ul_s);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin m_b[i] = 4'h0; m_s[i] = 2'b00; end
    m_result = 4'h0;
  endtask

  task automatic write_entry(input logic [2:0] addr, input logic [3:0] b, input logic [1:0] s);
    prog_we = 1'b1; prog_addr = addr; prog_b = b; prog_s = s;
    tick();
    prog_we = 1'b0;
    if (addr < 3'd4) begin m_b[addr] = b; m_s[addr] = s; end
  endtask

  task automatic load_test1();
    write_entry(3'd0, 4'b1100, 2'b01);
    write_entry(3'd1, 4'b1010, 2'b10);
    write_entry(3'd2, 4'b0000, 2'b11);
    write_entry(3'd3, 4'b0110, 2'b00);
  endtask

  task automatic run_check(input logic [3:0] a, input logic [2:0] len, input bit inject,
                           input bit hold_done, input string tag);
    logic [3:0] acc;
    acc = a;
    prog_len = len; a_in = a; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < int'(len); k++) begin
      if (inject && k == 1) begin
        start = 1'b1; prog_len = 3'd1;
        prog_we = 1'b1; prog_addr = 3'd0; prog_b = 4'hF; prog_s = 2'b11;
      end
      if (inject && k == 2) begin start = 1'b0; prog_we = 1'b0; end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL %s run_flags k=%0d busy=%b done=%b exp busy=1 done=0", tag, k, busy, done);
      end
      checks++;
      if (ul_a !== acc || ul_b !== m_b[k] || ul_s !== m_s[k]) begin
        failures++;
        $display("FAIL %s ul_drive k=%0d got a=%b b=%b s=%b exp a=%b b=%b s=%b",
                 tag, k, ul_a, ul_b, ul_s, acc, m_b[k], m_s[k]);
      end
      acc = ul4_f(acc, m_b[k], m_s[k]);
      tick();
    end
    m_result = acc;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ul_a !== 4'h0 || ul_s !== 2'b00) begin
      failures++;
      $display("FAIL %s done_cycle done=%b busy=%b ul_a=%b ul_s=%b exp done=1 busy=0 ul_a=0000 ul_s=00",
               tag, done, busy, ul_a, ul_s);
    end
    checks++;
    if (result !== m_result) begin
      failures++;
      $display("FAIL %s result got=%b exp=%b", tag, result, m_result);
    end
    if (!hold_done) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== m_result) begin
        failures++;
        $display("FAIL %s after_done done=%b busy=%b result=%b exp done=0 busy=0 result=%b",
                 tag, done, busy, result, m_result);
      end
    end
  endtask

  task automatic invalid_start(input logic [2:0] len, input string tag);
    prog_len = len; a_in = 4'($urandom); start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || result !== m_result) begin
      failures++;
      $display("FAIL %s err_pulse len=%0d err=%b busy=%b result=%b exp err=1 busy=0 result=%b",
               tag, len, err, busy, result, m_result);
    end
    tick();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s err_clear err=%b busy=%b done=%b exp 0 0 0", tag, err, busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_clear();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || result !== 4'h0 ||
        ul_a !== 4'h0 || ul_b !== 4'h0 || ul_s !== 2'b00) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b err=%b result=%b ul=%b/%b/%b exp all zero",
               busy, done, err, result, ul_a, ul_b, ul_s);
    end
  endtask

  task automatic test_program();
    load_test1();
    run_check(4'b0011, 3'd4, 1'b0, 1'b0, "prog4");
    checks++;
    if (result !== 4'b0010) begin
      failures++;
      $display("FAIL prog4_const result got=%b exp=0010", result);
    end
  endtask

  task automatic test_single();
    write_entry(3'd0, 4'b0000, 2'b00);
    run_check(4'b1111, 3'd1, 1'b0, 1'b0, "single");
  endtask

  task automatic test_invalid();
    invalid_start(3'd0, "len0");
    invalid_start(3'd5, "len5");
    invalid_start(3'd7, "len7");
  endtask

  task automatic test_ignore_during_run();
    load_test1();
    run_check(4'b0011, 3'd4, 1'b1, 1'b0, "inject");
    run_check(4'b0011, 3'd4, 1'b0, 1'b0, "rerun");
  endtask

  task automatic test_reset_abort();
    load_test1();
    prog_len = 3'd4; a_in = 4'b0011; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 4'h0 || ul_a !== 4'h0) begin
      failures++;
      $display("FAIL abort busy=%b done=%b result=%b ul_a=%b exp 0 0 0000 0000",
               busy, done, result, ul_a);
    end
    run_check(4'b1011, 3'd1, 1'b0, 1'b0, "post_abort");
  endtask

  task automatic test_back_to_back();
    load_test1();
    run_check(4'b0011, 3'd4, 1'b0, 1'b1, "b2b_first");
    start = 1'b1; prog_len = 3'd1; a_in = 4'b0101;
    prog_we = 1'b1; prog_addr = 3'd0; prog_b = 4'b0011; prog_s = 2'b01;
    tick();
    start = 1'b0; prog_we = 1'b0;
    m_b[0] = 4'b0011; m_s[0] = 2'b01;
    checks++;
    if (busy !== 1'b1 || ul_a !== 4'b0101 || ul_b !== 4'b0011 || ul_s !== 2'b01) begin
      failures++;
      $display("FAIL b2b_run busy=%b ul=%b/%b/%b exp 1 0101/0011/01", busy, ul_a, ul_b, ul_s);
    end
    tick();
    checks++;
    if (done !== 1'b1 || result !== 4'b0111) begin
      failures++;
      $display("FAIL b2b_done done=%b result=%b exp 1 0111", done, result);
    end
    m_result = 4'b0111;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      for (int w = 0; w < 3; w++)
        write_entry(3'($urandom_range(0, 7)), 4'($urandom), 2'($urandom));
      if ($urandom_range(0, 5) == 0)
        invalid_start(($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(5, 7)), "rnd_inv");
      run_check(4'($urandom), 3'($urandom_range(1, 4)), 1'b0, 1'b0, "rnd");
    end
  endtask

  initial begin
    reset = 1'b0; prog_we = 1'b0; start = 1'b0;
    prog_addr = '0; prog_b = '0; prog_s = '0; a_in = '0; prog_len = '0;
    model_clear();
    test_reset();
    test_program();
    test_single();
    test_invalid();
    test_ignore_during_run();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
